// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and constants for the 16:1 MUX round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, GAP)
//   NUM_REQ     : requester count, fixed by the 4-bit MUX select
//   SEL_W       : select / pointer width, log2(NUM_REQ)
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage : mux_arb_pkg

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin priority encoder. Searches the request vector
// cyclically starting at the pointer (15 wraps to 0) and returns the first
// asserted index. Holds no state.
// Ports:
//   req_i  in  NUM_REQ  request vector
//   ptr_i  in  SEL_W    highest-priority index for this search
//   win_o  out SEL_W    winning index (0 when no request)
//   any_o  out 1        at least one request asserted
// -----------------------------------------------------------------------------
module rr_priority_picker
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   win_o,
  output logic               any_o
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    // Walk from the pointer upward; the SEL_W-bit add wraps naturally mod 16.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr_i + SEL_W'(i);
      if (!any_o && req_i[idx]) begin
        win_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule : rr_priority_picker

// File: rtl/mux_16_1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_16_1_rr_arbiter
// Round-robin arbiter sharing one 16:1 MUX among 16 requesters. A registered
// one-hot grant drives the MUX select/enable. A grant is held until its owner
// drops its request; a one-cycle GAP with the MUX disabled separates owners.
//
// Optional feature (macro MUX_ARB_TIMEOUT_EN): a hold counter forces release
// after MAX_HOLD consecutive GRANT cycles and pulses Timeout_Out in the GAP.
// Without the macro a grant is held indefinitely and Timeout_Out is 0.
//
// Ports:
//   Clock_In      in  1       clock, rising edge
//   Reset_N_In    in  1       asynchronous active-low reset
//   Arb_Enable_In in  1       1 = new grants allowed
//   Request_In    in  16      per-requester request
//   Grant_Out     out 16      one-hot grant (registered)
//   Select_Out    out SEL_W   owner index -> MUX Select_In
//   Enable_Out    out 1       1 only in GRANT -> MUX Enable_In
//   Busy_Out      out 1       1 in GRANT or GAP
//   Timeout_Out   out 1       1-cycle pulse on forced release
// -----------------------------------------------------------------------------
module mux_16_1_rr_arbiter
  import mux_arb_pkg::*;
`ifdef MUX_ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 8
)
`endif
(
  input  logic               Clock_In,
  input  logic               Reset_N_In,
  input  logic               Arb_Enable_In,
  input  logic [NUM_REQ-1:0] Request_In,
  output logic [NUM_REQ-1:0] Grant_Out,
  output logic [SEL_W-1:0]   Select_Out,
  output logic               Enable_Out,
  output logic               Busy_Out,
  output logic               Timeout_Out
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               timeout_q, timeout_d;

  logic [SEL_W-1:0]   win;
  logic               any_req;
  logic               owner_rel;
  logic               force_rel;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]  hold_q, hold_d;
`endif

  rr_priority_picker u_picker (
    .req_i (Request_In),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    owner_rel = 1'b0;
    force_rel = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif

    unique case (state_q)
      IDLE, GAP: begin
        // GAP arbitrates exactly like IDLE; the pointer already moved past
        // the last owner, so it cannot win back-to-back against others.
        if (Arb_Enable_In && any_req) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << win;
          sel_d   = win;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end

      GRANT: begin
        // Arb_Enable_In and other requests are deliberately ignored here.
        owner_rel = !Request_In[sel_q];
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d    = hold_q + HOLD_W'(1);
        force_rel = !owner_rel && (hold_d == HOLD_W'(MAX_HOLD));
`endif
        if (owner_rel || force_rel) begin
          state_d   = GAP;
          grant_d   = '0;
          ptr_d     = sel_q + SEL_W'(1);
          timeout_d = force_rel;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign Grant_Out   = grant_q;
  assign Select_Out  = sel_q;
  assign Enable_Out  = (state_q == GRANT);
  assign Busy_Out    = (state_q != IDLE);
  assign Timeout_Out = timeout_q;

endmodule : mux_16_1_rr_arbiter

// File: tb/tb_mux_16_1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_16_1_rr_arbiter
// Directed-vector bench with a scoreboard. Each stimulus cycle pushes the
// hand-derived expected outputs for the following clock edge; a separate
// monitor pops and compares one entry after every rising edge.
// Honours MUX_ARB_TIMEOUT_EN for the hold-timeout expectations.
// -----------------------------------------------------------------------------
module tb_mux_16_1_rr_arbiter;

  localparam int S_IDLE  = 0;
  localparam int S_GRANT = 1;
  localparam int S_GAP   = 2;

  typedef struct {
    logic [15:0] g;
    logic [3:0]  s;
    logic        e;
    logic        b;
    logic        t;
    string       tag;
  } exp_t;

  logic        Clock_In;
  logic        Reset_N_In;
  logic        Arb_Enable_In;
  logic [15:0] Request_In;
  logic [15:0] Grant_Out;
  logic [3:0]  Select_Out;
  logic        Enable_Out;
  logic        Busy_Out;
  logic        Timeout_Out;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  mux_16_1_rr_arbiter dut (
    .Clock_In      (Clock_In),
    .Reset_N_In    (Reset_N_In),
    .Arb_Enable_In (Arb_Enable_In),
    .Request_In    (Request_In),
    .Grant_Out     (Grant_Out),
    .Select_Out    (Select_Out),
    .Enable_Out    (Enable_Out),
    .Busy_Out      (Busy_Out),
    .Timeout_Out   (Timeout_Out)
  );

  initial begin
    Clock_In = 1'b0;
    forever #5 Clock_In = ~Clock_In;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Monitor: compare one scoreboard entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock_In);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (Grant_Out !== e.g || Select_Out !== e.s || Enable_Out !== e.e ||
            Busy_Out !== e.b || Timeout_Out !== e.t) begin
          failures++;
          $display("FAIL %s got grant=%h sel=%0d en=%b busy=%b to=%b, want grant=%h sel=%0d en=%b busy=%b to=%b",
                   e.tag, Grant_Out, Select_Out, Enable_Out, Busy_Out, Timeout_Out,
                   e.g, e.s, e.e, e.b, e.t);
        end
      end
    end
  end

  // One stimulus cycle: apply inputs, queue expected outputs after next edge.
  task automatic step(input logic [15:0] req, input logic en, input int st,
                      input int own, input logic to, input string tag);
    exp_t e;
    logic [3:0] o;
    @(negedge Clock_In);
    #1;
    Request_In    = req;
    Arb_Enable_In = en;
    o     = own[3:0];
    e.g   = (st == S_GRANT) ? (16'h0001 << o) : 16'h0000;
    e.s   = o;
    e.e   = (st == S_GRANT);
    e.b   = (st != S_IDLE);
    e.t   = to;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (Grant_Out !== 16'h0 || Select_Out !== 4'h0 || Enable_Out !== 1'b0 ||
        Busy_Out !== 1'b0 || Timeout_Out !== 1'b0) begin
      failures++;
      $display("FAIL %s got grant=%h sel=%0d en=%b busy=%b to=%b, want all zero",
               tag, Grant_Out, Select_Out, Enable_Out, Busy_Out, Timeout_Out);
    end
  endtask

  task automatic do_reset(input logic [15:0] req, input string tag);
    @(negedge Clock_In);
    Request_In = req;
    Reset_N_In = 1'b0;
    #1;
    check_zero({tag, "_async"});
    repeat (2) @(negedge Clock_In);
    check_zero({tag, "_held"});
    Request_In = 16'h0;
    Reset_N_In = 1'b1;
  endtask

  initial begin
    int wait_cnt;
    Reset_N_In    = 1'b1;
    Arb_Enable_In = 1'b1;
    Request_In    = 16'hFFFF;
    #2;

    // 1: reset with all requests high, then idle
    do_reset(16'hFFFF, "reset");
    step(16'h0000, 1'b1, S_IDLE, 0, 1'b0, "t1_idle0");
    step(16'h0000, 1'b1, S_IDLE, 0, 1'b0, "t1_idle1");

    // 2: single requester 4, release, gap, idle
    step(16'h0010, 1'b1, S_GRANT, 4, 1'b0, "t2_grant4");
    step(16'h0010, 1'b1, S_GRANT, 4, 1'b0, "t2_hold4");
    step(16'h0000, 1'b1, S_GAP,   4, 1'b0, "t2_gap");
    step(16'h0000, 1'b1, S_IDLE,  4, 1'b0, "t2_idle");

    // 3: requesters 0 and 15 alternate, pointer wraps 15->0
    do_reset(16'h0000, "reset3");
    step(16'h8001, 1'b1, S_GRANT, 0,  1'b0, "t3_g0a");
    step(16'h8001, 1'b1, S_GRANT, 0,  1'b0, "t3_h0a");
    step(16'h8000, 1'b1, S_GAP,   0,  1'b0, "t3_gap0a");
    step(16'h8001, 1'b1, S_GRANT, 15, 1'b0, "t3_g15a");
    step(16'h8001, 1'b1, S_GRANT, 15, 1'b0, "t3_h15a");
    step(16'h0001, 1'b1, S_GAP,   15, 1'b0, "t3_gap15a");
    step(16'h8001, 1'b1, S_GRANT, 0,  1'b0, "t3_g0b");
    step(16'h8001, 1'b1, S_GRANT, 0,  1'b0, "t3_h0b");
    step(16'h8000, 1'b1, S_GAP,   0,  1'b0, "t3_gap0b");
    step(16'h8001, 1'b1, S_GRANT, 15, 1'b0, "t3_g15b");
    step(16'h8001, 1'b1, S_GRANT, 15, 1'b0, "t3_h15b");
    step(16'h0001, 1'b1, S_GAP,   15, 1'b0, "t3_gap15b");
    step(16'h0000, 1'b1, S_IDLE,  15, 1'b0, "t3_idle");

    // 4: owner 3 drops while 7 rises in the same cycle
    step(16'h0008, 1'b1, S_GRANT, 3, 1'b0, "t4_g3");
    step(16'h0008, 1'b1, S_GRANT, 3, 1'b0, "t4_h3");
    step(16'h0080, 1'b1, S_GAP,   3, 1'b0, "t4_gap3");
    step(16'h0080, 1'b1, S_GRANT, 7, 1'b0, "t4_g7");
    step(16'h0000, 1'b1, S_GAP,   7, 1'b0, "t4_gap7");
    step(16'h0000, 1'b1, S_IDLE,  7, 1'b0, "t4_idle");

    // 5: pointer at 8; requester 2 wins by wrap; enable low blocks next grant
    step(16'h0004, 1'b1, S_GRANT, 2, 1'b0, "t5_g2");
    step(16'h0004, 1'b0, S_GRANT, 2, 1'b0, "t5_h2_dis");
    step(16'h0104, 1'b0, S_GRANT, 2, 1'b0, "t5_nopreempt");
    step(16'h0100, 1'b0, S_GAP,   2, 1'b0, "t5_gap2");
    step(16'h0100, 1'b0, S_IDLE,  2, 1'b0, "t5_blocked0");
    step(16'h0100, 1'b0, S_IDLE,  2, 1'b0, "t5_blocked1");
    step(16'h0100, 1'b1, S_GRANT, 8, 1'b0, "t5_g8");
    step(16'h0000, 1'b1, S_GAP,   8, 1'b0, "t5_gap8");
    step(16'h0000, 1'b1, S_IDLE,  8, 1'b0, "t5_idle");

    // 6: requester 2 held 20 cycles
    for (int i = 0; i < 20; i++) begin
`ifdef MUX_ARB_TIMEOUT_EN
      if ((i % 9) == 8)
        step(16'h0004, 1'b1, S_GAP, 2, 1'b1, $sformatf("t6_timeout%0d", i));
      else
        step(16'h0004, 1'b1, S_GRANT, 2, 1'b0, $sformatf("t6_grant%0d", i));
`else
      step(16'h0004, 1'b1, S_GRANT, 2, 1'b0, $sformatf("t6_grant%0d", i));
`endif
    end
    step(16'h0000, 1'b1, S_GAP,  2, 1'b0, "t6_gap");
    step(16'h0000, 1'b1, S_IDLE, 2, 1'b0, "t6_idle");

    // 7: pointer now 3, requester 1 granted; async reset mid-GRANT
    step(16'h0002, 1'b1, S_GRANT, 1, 1'b0, "t7_g1");
    @(posedge Clock_In);
    #3;
    Reset_N_In = 1'b0;
    #1;
    check_zero("t7_async_reset");
    @(negedge Clock_In);
    Request_In = 16'h0000;
    Reset_N_In = 1'b1;
    step(16'h0000, 1'b1, S_IDLE,  0, 1'b0, "t7_nogap");
    // Pointer back at 0: requester 0 must beat 15.
    step(16'h8001, 1'b1, S_GRANT, 0, 1'b0, "t7_ptr0");
    step(16'h8000, 1'b1, S_GAP,   0, 1'b0, "t7_gap0");
    step(16'h0000, 1'b1, S_IDLE,  0, 1'b0, "t7_idle");

    // Drain scoreboard with a bounded wait.
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge Clock_In);
      wait_cnt++;
    end
    repeat (2) @(posedge Clock_In);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending, want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_16_1_rr_arbiter
